// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults, count-width helper and status error-bit indices
package fifo_pkg;
  localparam int A_WIDTH = 4;
  localparam int D_WIDTH = 16;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;
  localparam int OVF = 0;
  localparam int UDF = 1;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: producer/consumer handshake, data and status bundle of the FIFO
interface sync_fifo_ctrl_if #(
  parameter int a_width = 4,
  parameter int d_width = 16
);
  logic wr_en;
  logic [d_width-1:0] wr_data;
  logic rd_en;
  logic [d_width-1:0] rd_data;
  logic rd_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [a_width:0] count;
  logic overflow;
  logic underflow;
  logic err_clr;
  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write and asynchronous read
module fifo_mem #(
  parameter int a_width = 4,
  parameter int d_width = 16
) (
  input  logic               Clk,
  input  logic               we,
  input  logic [a_width-1:0] wa,
  input  logic [d_width-1:0] wd,
  input  logic [a_width-1:0] ra,
  output logic [d_width-1:0] rd
);
  logic [d_width-1:0] mem [2**a_width];
  always_ff @(posedge Clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int a_width  = A_WIDTH,
  parameter int d_width  = D_WIDTH,
  parameter int af_level = AF_LEVEL,
  parameter int ae_level = AE_LEVEL
) (
  input logic Clk,
  input logic Rst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int cw = cnt_width(2**a_width);
  localparam int pw = a_width + 1;
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] cnt, cnt_n;
  logic [1:0] err;
  logic full_q, empty_q, af_q, ae_q, wr_ok, rd_ok;
  logic [d_width-1:0] head;
  assign wr_ok = bus.wr_en && !full_q;
  assign rd_ok = bus.rd_en && !empty_q;
  assign cnt_n = cnt + cw'(wr_ok) - cw'(rd_ok);
  fifo_mem #(.a_width(a_width), .d_width(d_width)) u_mem (
    .Clk(Clk),
    .we (wr_ok),
    .wa (wr_ptr[a_width-1:0]),
    .wd (bus.wr_data),
    .ra (rd_ptr[a_width-1:0]),
    .rd (head)
  );
  // flags are derived from the next count so they line up with count itself
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr + pw'(wr_ok);
      rd_ptr   <= rd_ptr + pw'(rd_ok);
      cnt      <= cnt_n;
      full_q   <= cnt_n == cw'(2**a_width);
      empty_q  <= cnt_n == '0;
      af_q     <= cnt_n >= cw'(af_level);
      ae_q     <= cnt_n <= cw'(ae_level);
      err[OVF] <= (err[OVF] && !bus.err_clr) || (bus.wr_en && full_q);
      err[UDF] <= (err[UDF] && !bus.err_clr) || (bus.rd_en && empty_q);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = empty_q ? '0 : head;
  assign bus.rd_valid = !empty_q;
`else
  logic [d_width-1:0] rd_q;
  logic rv_q;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_ok;
      if (rd_ok) rd_q <= head;
    end
  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rv_q;
`endif
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = err[OVF];
  assign bus.underflow    = err[UDF];
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed table, corner sequences and random traffic checked against a queue model
module tb_sync_fifo_ctrl;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit fw = 1'b1;
`else
  localparam bit fw = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  sync_fifo_ctrl_if #(.a_width(4), .d_width(16)) bus ();
  sync_fifo_ctrl #(.a_width(4), .d_width(16), .af_level(14), .ae_level(2)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus)
  );
  always #5 Clk = ~Clk;
  int total = 0;
  int bad = 0;
  logic [15:0] q[$];
  logic m_ovf, m_udf, m_rv;
  logic [15:0] m_rd;
  typedef struct {
    logic w; logic [15:0] d; logic r; logic c;
    int cnt; logic rv; logic [15:0] rd; logic udf;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rd = '0;
  endtask

  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, ".count"}, 32'(bus.count), n);
    chk({tag, ".full"}, 32'(bus.full), 32'(n == 16));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= 14));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= 2));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(bus.underflow), 32'(m_udf));
    chk({tag, ".rv"}, 32'(bus.rd_valid), 32'(m_rv));
    chk({tag, ".rd"}, 32'(bus.rd_data), 32'(m_rd));
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c, input string tag);
    int n;
    logic wa, ra;
    bus.wr_en = w; bus.wr_data = d; bus.rd_en = r; bus.err_clr = c;
    @(posedge Clk);
    n = q.size();
    wa = w && n < 16;
    ra = r && n > 0;
    m_ovf = (m_ovf && !c) || (w && n == 16);
    m_udf = (m_udf && !c) || (r && n == 0);
    m_rv = ra;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(d);
    if (fw) begin
      m_rv = q.size() > 0;
      m_rd = m_rv ? q[0] : 16'h0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.rd_en = 0; bus.err_clr = 0;
    m_reset();
    tv[0] = '{1, 16'h1111, 0, 0, 1, fw, fw ? 16'h1111 : 16'h0, 0};
    tv[1] = '{1, 16'h2222, 0, 0, 2, fw, fw ? 16'h1111 : 16'h0, 0};
    tv[2] = '{1, 16'h3333, 1, 0, 2, 1, fw ? 16'h2222 : 16'h1111, 0};
    tv[3] = '{0, 16'h0, 1, 0, 1, 1, fw ? 16'h3333 : 16'h2222, 0};
    tv[4] = '{0, 16'h0, 0, 0, 1, fw, fw ? 16'h3333 : 16'h2222, 0};
    tv[5] = '{0, 16'h0, 1, 0, 0, !fw, fw ? 16'h0 : 16'h3333, 0};
    tv[6] = '{0, 16'h0, 1, 0, 0, 0, fw ? 16'h0 : 16'h3333, 1};
    tv[7] = '{0, 16'h0, 0, 1, 0, 0, fw ? 16'h0 : 16'h3333, 0};
    tv[8] = '{0, 16'h0, 1, 1, 0, 0, fw ? 16'h0 : 16'h3333, 1};
    tv[9] = '{0, 16'h0, 0, 1, 0, 0, fw ? 16'h0 : 16'h3333, 0};
    #12;
    check_all("reset");
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(tv[i].w, tv[i].d, tv[i].r, tv[i].c, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d.count", i), 32'(bus.count), tv[i].cnt);
      chk($sformatf("tv%0d.rv", i), 32'(bus.rd_valid), 32'(tv[i].rv));
      chk($sformatf("tv%0d.rd", i), 32'(bus.rd_data), 32'(tv[i].rd));
      chk($sformatf("tv%0d.udf", i), 32'(bus.underflow), 32'(tv[i].udf));
    end
    for (int i = 0; i < 3; i++) step(1, 16'(16'h50 + i), 0, 0, "prerst");
    step(0, 0, 1, 0, "prerst_rd");
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(bus.count), 0);
    chk("async_rst.empty", 32'(bus.empty), 1);
    chk("async_rst.aempty", 32'(bus.almost_empty), 1);
    chk("async_rst.rv", 32'(bus.rd_valid), 0);
    m_reset();
    #2 Rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1, 16'(i), 0, 0, "fill");
      chk("fill.afull", 32'(bus.almost_full), 32'(i >= 13));
      chk("fill.full", 32'(bus.full), 32'(i == 15));
    end
    step(1, 16'hDEAD, 0, 0, "fill17");
    chk("fill17.ovf", 32'(bus.overflow), 1);
    chk("fill17.count", 32'(bus.count), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, "drain");
      chk("drain.rd", 32'(bus.rd_data), fw ? (i < 15 ? i + 1 : 0) : i);
    end
    step(0, 0, 1, 0, "drain17");
    chk("drain17.udf", 32'(bus.underflow), 1);
    chk("drain17.rv", 32'(bus.rd_valid), 0);
    step(0, 0, 0, 1, "clr");
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 0, "wrap_w");
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "wrap_r");
    end
    chk("wrap.count", 32'(bus.count), 0);
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, "sim_fill");
    for (int i = 0; i < 20; i++) begin
      step(1, 16'($urandom), 1, 0, "sim");
      chk("sim.count", 32'(bus.count), 8);
    end
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, "to_full");
    step(1, 16'hBEEF, 1, 0, "full_rw");
    chk("full_rw.count", 32'(bus.count), 15);
    chk("full_rw.ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, "to_empty");
    step(1, 16'hCAFE, 1, 0, "empty_rw");
    chk("empty_rw.count", 32'(bus.count), 1);
    chk("empty_rw.udf", 32'(bus.underflow), 1);
    step(0, 0, 1, 1, "clr2");
    step(1, 16'hA5A5, 0, 0, "fwft");
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft.rv", 32'(bus.rd_valid), 1);
    chk("fwft.rd", 32'(bus.rd_data), 32'hA5A5);
`endif
    for (int i = 0; i < 600; i++) begin
      int bias = (i / 100) % 2 ? 70 : 35;
      step(32'($urandom_range(0, 99)) < bias, 16'($urandom), 32'($urandom_range(0, 99)) < 100 - bias,
           $urandom_range(0, 19) == 0, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
